// File: rtl/vga_timing_pattern_gen.sv
// VGA timing generator with a built-in test-pattern engine: programmable porches, sync
// widths and polarity, plus black / horizontal bars / vertical bars / window-box patterns.
module vga_timing_pattern_gen #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int SYNC_ACTIVE = 0,
    parameter int NUM_BARS    = 4,
    parameter int CNT_W       = 11
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             iPixelEn,
    input  logic [1:0]       iMode,
    output logic             oHorizontal_Sync,
    output logic             oVertical_Sync,
    output logic             oVGA_R,
    output logic             oVGA_G,
    output logic             oVGA_B,
    output logic             oActive,
    output logic [CNT_W-1:0] oCol,
    output logic [CNT_W-1:0] oRow,
    output logic             oFrameStart
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_BAR   = H_ACTIVE / NUM_BARS;
    localparam int V_BAR   = V_ACTIVE / NUM_BARS;

    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT      = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT      = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] H_ACT_LAST = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] V_ACT_LAST = CNT_W'(V_ACTIVE - 1);
    localparam logic [CNT_W-1:0] H_SYNC_ON  = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SYNC_OFF = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_ON  = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SYNC_OFF = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] H_BAR_LAST = CNT_W'(H_BAR - 1);
    localparam logic [CNT_W-1:0] V_BAR_LAST = CNT_W'(V_BAR - 1);
    localparam logic [CNT_W-1:0] BOX_L      = CNT_W'(H_ACTIVE / 8);
    localparam logic [CNT_W-1:0] BOX_R      = CNT_W'(7 * H_ACTIVE / 8);
    localparam logic [CNT_W-1:0] BOX_T      = CNT_W'(V_ACTIVE / 8);
    localparam logic [CNT_W-1:0] BOX_B      = CNT_W'(7 * V_ACTIVE / 8);
    localparam logic             SYNC_LVL   = (SYNC_ACTIVE != 0);

    localparam logic [1:0] MODE_BLACK = 2'b00;
    localparam logic [1:0] MODE_HBARS = 2'b01;
    localparam logic [1:0] MODE_VBARS = 2'b10;
    localparam logic [1:0] MODE_BOX   = 2'b11;

    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] vcnt;
    logic [CNT_W-1:0] hpos;
    logic [CNT_W-1:0] vpos;
    logic [2:0]       hbar;
    logic [2:0]       vbar;
    logic [1:0]       mode;
    logic             frame_tick;
    logic             h_wrap;
    logic             v_wrap;
    logic             frame_wrap;
    logic             active;
    logic             in_box;
    logic             hsync_on;
    logic             vsync_on;
    logic [2:0]       rgb;

    function automatic logic [2:0] palette(input logic [2:0] idx);
        logic [2:0] c;
        case (idx)
            3'd0:    c = 3'b010;
            3'd1:    c = 3'b100;
            3'd2:    c = 3'b101;
            3'd3:    c = 3'b001;
            3'd4:    c = 3'b011;
            3'd5:    c = 3'b110;
            3'd6:    c = 3'b111;
            default: c = 3'b000;
        endcase
        return c;
    endfunction

    assign h_wrap     = (hcnt == H_LAST);
    assign v_wrap     = (vcnt == V_LAST);
    assign frame_wrap = h_wrap && v_wrap;
    assign active     = (hcnt < H_ACT) && (vcnt < V_ACT);
    assign hsync_on   = (hcnt >= H_SYNC_ON) && (hcnt < H_SYNC_OFF);
    assign vsync_on   = (vcnt >= V_SYNC_ON) && (vcnt < V_SYNC_OFF);
    assign in_box     = (hcnt >= BOX_L) && (hcnt < BOX_R) && (vcnt >= BOX_T) && (vcnt < BOX_B);

    // Counters and bar trackers; bar counters freeze on the last active pixel/line
    // so they never run past NUM_BARS-1 in the blanking region.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            hcnt       <= '0;
            vcnt       <= '0;
            hpos       <= '0;
            vpos       <= '0;
            hbar       <= '0;
            vbar       <= '0;
            mode       <= MODE_BLACK;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= iPixelEn && frame_wrap;
            if (iPixelEn) begin
                if (frame_wrap) begin
                    mode <= iMode;
                end
                if (h_wrap) begin
                    hcnt <= '0;
                    hpos <= '0;
                    hbar <= '0;
                    if (v_wrap) begin
                        vcnt <= '0;
                        vpos <= '0;
                        vbar <= '0;
                    end else begin
                        vcnt <= vcnt + ONE;
                        if (vcnt < V_ACT_LAST) begin
                            if (vpos == V_BAR_LAST) begin
                                vpos <= '0;
                                vbar <= vbar + 3'd1;
                            end else begin
                                vpos <= vpos + ONE;
                            end
                        end
                    end
                end else begin
                    hcnt <= hcnt + ONE;
                    if (hcnt < H_ACT_LAST) begin
                        if (hpos == H_BAR_LAST) begin
                            hpos <= '0;
                            hbar <= hbar + 3'd1;
                        end else begin
                            hpos <= hpos + ONE;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        rgb = 3'b000;
        if (active) begin
            case (mode)
                MODE_HBARS: rgb = palette(vbar);
                MODE_VBARS: rgb = palette(hbar);
                MODE_BOX:   rgb = in_box ? 3'b111 : 3'b000;
                default:    rgb = 3'b000;
            endcase
        end
    end

    // Output registers: every output reflects the counter state of the previous clock.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            oHorizontal_Sync <= ~SYNC_LVL;
            oVertical_Sync   <= ~SYNC_LVL;
            oVGA_R           <= 1'b0;
            oVGA_G           <= 1'b0;
            oVGA_B           <= 1'b0;
            oActive          <= 1'b0;
            oCol             <= '0;
            oRow             <= '0;
            oFrameStart      <= 1'b0;
        end else begin
            oHorizontal_Sync <= hsync_on ? SYNC_LVL : ~SYNC_LVL;
            oVertical_Sync   <= vsync_on ? SYNC_LVL : ~SYNC_LVL;
            oVGA_R           <= rgb[2];
            oVGA_G           <= rgb[1];
            oVGA_B           <= rgb[0];
            oActive          <= active;
            oCol             <= hcnt;
            oRow             <= vcnt;
            oFrameStart      <= frame_tick;
        end
    end

endmodule

// File: tb/tb_vga_timing_pattern_gen.sv
// Bench for vga_timing_pattern_gen: two reduced-size instances (active-low 4 bars,
// active-high 8 bars) driven by random pixel ticks and checked against a frame-level model.
module tb_vga_timing_pattern_gen;

    localparam int HA[2] = '{32, 40};
    localparam int HF[2] = '{4, 2};
    localparam int HS[2] = '{4, 6};
    localparam int HB[2] = '{4, 3};
    localparam int VA[2] = '{16, 24};
    localparam int VF[2] = '{2, 1};
    localparam int VS[2] = '{2, 3};
    localparam int VB[2] = '{2, 2};
    localparam int SA[2] = '{0, 1};
    localparam int NB[2] = '{4, 8};

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic [2:0]  rgb;
        logic        act;
        logic        fs;
        logic [10:0] col;
        logic [10:0] row;
    } out_t;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        iPixelEn;
    logic [1:0]  iMode;
    logic        hs[2];
    logic        vs[2];
    logic        r[2];
    logic        g[2];
    logic        b[2];
    logic        act[2];
    logic        fs[2];
    logic [10:0] col[2];
    logic [10:0] row[2];

    always #5 Clock = ~Clock;

    vga_timing_pattern_gen #(
        .H_ACTIVE(HA[0]), .H_FP(HF[0]), .H_SYNC(HS[0]), .H_BP(HB[0]),
        .V_ACTIVE(VA[0]), .V_FP(VF[0]), .V_SYNC(VS[0]), .V_BP(VB[0]),
        .SYNC_ACTIVE(SA[0]), .NUM_BARS(NB[0]), .CNT_W(11)
    ) dut_a (
        .Clock(Clock), .Reset(Reset), .iPixelEn(iPixelEn), .iMode(iMode),
        .oHorizontal_Sync(hs[0]), .oVertical_Sync(vs[0]),
        .oVGA_R(r[0]), .oVGA_G(g[0]), .oVGA_B(b[0]), .oActive(act[0]),
        .oCol(col[0]), .oRow(row[0]), .oFrameStart(fs[0])
    );

    vga_timing_pattern_gen #(
        .H_ACTIVE(HA[1]), .H_FP(HF[1]), .H_SYNC(HS[1]), .H_BP(HB[1]),
        .V_ACTIVE(VA[1]), .V_FP(VF[1]), .V_SYNC(VS[1]), .V_BP(VB[1]),
        .SYNC_ACTIVE(SA[1]), .NUM_BARS(NB[1]), .CNT_W(11)
    ) dut_b (
        .Clock(Clock), .Reset(Reset), .iPixelEn(iPixelEn), .iMode(iMode),
        .oHorizontal_Sync(hs[1]), .oVertical_Sync(vs[1]),
        .oVGA_R(r[1]), .oVGA_G(g[1]), .oVGA_B(b[1]), .oActive(act[1]),
        .oCol(col[1]), .oRow(row[1]), .oFrameStart(fs[1])
    );

    int         vectors = 0;
    int         miscompares = 0;
    string      scen = "init";

    int         mh[2];
    int         mv[2];
    logic [1:0] mmode[2];
    logic       mft[2];
    out_t       exp_o[2];
    out_t       got[2];
    logic       prev_hs[2];
    logic       prev_vs[2];
    int         hs_pulses[2];
    int         vs_pulses[2];
    int         tick_ctr;
    int         fs_tick[2];
    int         frame_len[2];
    logic       fs_hit[2];

    function automatic int h_total(input int i);
        return HA[i] + HF[i] + HS[i] + HB[i];
    endfunction

    function automatic int v_total(input int i);
        return VA[i] + VF[i] + VS[i] + VB[i];
    endfunction

    function automatic logic [2:0] ref_palette(input int idx);
        case (idx)
            0: return 3'b010;
            1: return 3'b100;
            2: return 3'b101;
            3: return 3'b001;
            4: return 3'b011;
            5: return 3'b110;
            6: return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [2:0] ref_rgb(input int i, input int h, input int v, input logic [1:0] m);
        if (!(h < HA[i] && v < VA[i])) return 3'b000;
        case (m)
            2'b01: return ref_palette(v / (VA[i] / NB[i]));
            2'b10: return ref_palette(h / (HA[i] / NB[i]));
            2'b11: return (h >= HA[i] / 8 && h < 7 * HA[i] / 8 &&
                           v >= VA[i] / 8 && v < 7 * VA[i] / 8) ? 3'b111 : 3'b000;
            default: return 3'b000;
        endcase
    endfunction

    // Reference: pixel position as plain integers, outputs describe the position held before the edge.
    task automatic model_edge(input int i);
        logic on_lvl;
        on_lvl = (SA[i] != 0);
        if (Reset) begin
            mh[i] = 0; mv[i] = 0; mmode[i] = 2'b00; mft[i] = 1'b0;
            exp_o[i] = '{hs: ~on_lvl, vs: ~on_lvl, rgb: 3'b000, act: 1'b0, fs: 1'b0,
                         col: 11'd0, row: 11'd0};
        end else begin
            exp_o[i].col = 11'(mh[i]);
            exp_o[i].row = 11'(mv[i]);
            exp_o[i].act = (mh[i] < HA[i]) && (mv[i] < VA[i]);
            exp_o[i].rgb = ref_rgb(i, mh[i], mv[i], mmode[i]);
            exp_o[i].hs  = (mh[i] >= HA[i] + HF[i] && mh[i] < HA[i] + HF[i] + HS[i]) ? on_lvl : ~on_lvl;
            exp_o[i].vs  = (mv[i] >= VA[i] + VF[i] && mv[i] < VA[i] + VF[i] + VS[i]) ? on_lvl : ~on_lvl;
            exp_o[i].fs  = mft[i];
            mft[i] = iPixelEn && (mh[i] == h_total(i) - 1) && (mv[i] == v_total(i) - 1);
            if (iPixelEn) begin
                if (mft[i]) mmode[i] = iMode;
                mh[i] = (mh[i] + 1) % h_total(i);
                if (mh[i] == 0) mv[i] = (mv[i] + 1) % v_total(i);
            end
        end
    endtask

    task automatic cycle();
        @(posedge Clock);
        model_edge(0);
        model_edge(1);
        if (Reset) begin
            tick_ctr = 0;
            fs_tick[0] = 0;
            fs_tick[1] = 0;
        end else if (iPixelEn) begin
            tick_ctr++;
        end
        @(negedge Clock);
        for (int i = 0; i < 2; i++) begin
            got[i] = {hs[i], vs[i], r[i], g[i], b[i], act[i], fs[i], col[i], row[i]};
            vectors++;
            if (got[i] !== exp_o[i]) begin
                miscompares++;
                $display("FAIL scoreboard[%s] dut%0d t=%0t got=%h expected=%h",
                         scen, i, $time, got[i], exp_o[i]);
            end
            if (got[i].hs == (SA[i] != 0) && prev_hs[i] != (SA[i] != 0)) hs_pulses[i]++;
            if (got[i].vs == (SA[i] != 0) && prev_vs[i] != (SA[i] != 0)) vs_pulses[i]++;
            prev_hs[i] = got[i].hs;
            prev_vs[i] = got[i].vs;
            if (got[i].fs === 1'b1) begin
                frame_len[i] = tick_ctr - fs_tick[i];
                fs_tick[i] = tick_ctr;
                fs_hit[i] = 1'b1;
            end
        end
    endtask

    task automatic do_reset(input logic [1:0] m);
        Reset = 1'b1;
        iPixelEn = 1'b0;
        iMode = m;
        cycle();
        cycle();
        Reset = 1'b0;
    endtask

    task automatic run_until_fs(input int i, input int budget, input bit alt);
        fs_hit[i] = 1'b0;
        for (int k = 0; k < budget && !fs_hit[i]; k++) begin
            iPixelEn = alt ? ~iPixelEn : ($urandom_range(3) != 0);
            cycle();
        end
        if (!fs_hit[i]) begin
            vectors++;
            miscompares++;
            $display("FAIL fs_timeout[%s] dut%0d no frame start within %0d clocks", scen, i, budget);
        end
    endtask

    task automatic test_reset();
        scen = "reset";
        do_reset(2'($urandom_range(3)));
        for (int i = 0; i < 2; i++) begin
            logic inact;
            inact = (SA[i] == 0);
            vectors += 6;
            if (got[i].hs !== inact) begin miscompares++; $display("FAIL reset_hs dut%0d got=%b exp=%b", i, got[i].hs, inact); end
            if (got[i].vs !== inact) begin miscompares++; $display("FAIL reset_vs dut%0d got=%b exp=%b", i, got[i].vs, inact); end
            if (got[i].rgb !== 3'b000) begin miscompares++; $display("FAIL reset_rgb dut%0d got=%b exp=000", i, got[i].rgb); end
            if (got[i].act !== 1'b0) begin miscompares++; $display("FAIL reset_active dut%0d got=%b exp=0", i, got[i].act); end
            if (got[i].col !== 11'd0 || got[i].row !== 11'd0) begin
                miscompares++; $display("FAIL reset_pos dut%0d got=%0d,%0d exp=0,0", i, got[i].col, got[i].row);
            end
            if (got[i].fs !== 1'b0) begin miscompares++; $display("FAIL reset_fs dut%0d got=%b exp=0", i, got[i].fs); end
        end
    endtask

    task automatic test_timing();
        for (int i = 0; i < 2; i++) begin
            scen = "timing";
            do_reset(2'b00);
            run_until_fs(i, 4 * h_total(i) * v_total(i), 1'b1);
            vectors++;
            if (frame_len[i] !== h_total(i) * v_total(i)) begin
                miscompares++;
                $display("FAIL first_frame_len dut%0d got=%0d exp=%0d", i, frame_len[i], h_total(i) * v_total(i));
            end
            hs_pulses[i] = 0;
            vs_pulses[i] = 0;
            run_until_fs(i, 4 * h_total(i) * v_total(i), 1'b1);
            vectors += 3;
            if (frame_len[i] !== h_total(i) * v_total(i)) begin
                miscompares++;
                $display("FAIL frame_len dut%0d got=%0d exp=%0d", i, frame_len[i], h_total(i) * v_total(i));
            end
            if (hs_pulses[i] !== v_total(i)) begin
                miscompares++; $display("FAIL hsync_pulses dut%0d got=%0d exp=%0d", i, hs_pulses[i], v_total(i));
            end
            if (vs_pulses[i] !== 1) begin
                miscompares++; $display("FAIL vsync_pulses dut%0d got=%0d exp=1", i, vs_pulses[i]);
            end
        end
    endtask

    task automatic test_bars(input logic [1:0] m);
        scen = (m == 2'b01) ? "hbars" : "vbars";
        do_reset(m);
        run_until_fs(1, 6000, 1'b0);
        run_until_fs(1, 6000, 1'b0);
    endtask

    task automatic test_mode_switch();
        scen = "mode_switch";
        do_reset(2'b01);
        run_until_fs(0, 4000, 1'b0);
        for (int k = 0; k < 4000 && got[0].row != 11'd10; k++) begin
            iPixelEn = ($urandom_range(3) != 0);
            cycle();
        end
        iMode = 2'b11;
        run_until_fs(0, 4000, 1'b0);
        run_until_fs(0, 4000, 1'b0);
    endtask

    task automatic test_reset_mid();
        scen = "reset_mid";
        iMode = 2'b10;
        repeat ($urandom_range(1500, 200)) begin
            iPixelEn = ($urandom_range(3) != 0);
            cycle();
        end
        Reset = 1'b1;
        iPixelEn = 1'b1;
        cycle();
        Reset = 1'b0;
        vectors += 3;
        if (got[0].hs !== 1'b1 || got[0].vs !== 1'b1) begin
            miscompares++; $display("FAIL midreset_sync got=%b%b exp=11", got[0].hs, got[0].vs);
        end
        if (got[0].rgb !== 3'b000) begin
            miscompares++; $display("FAIL midreset_rgb got=%b exp=000", got[0].rgb);
        end
        if (got[0].col !== 11'd0 || got[0].row !== 11'd0) begin
            miscompares++; $display("FAIL midreset_pos got=%0d,%0d exp=0,0", got[0].col, got[0].row);
        end
        iPixelEn = 1'b0;
        run_until_fs(0, 4 * h_total(0) * v_total(0), 1'b1);
        vectors++;
        if (frame_len[0] !== h_total(0) * v_total(0)) begin
            miscompares++;
            $display("FAIL midreset_frame_len got=%0d exp=%0d", frame_len[0], h_total(0) * v_total(0));
        end
    endtask

    task automatic test_random();
        scen = "random";
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(63) == 0) iMode = 2'($urandom_range(3));
            if ((k % 700) < 40) iPixelEn = 1'b0;
            else iPixelEn = ($urandom_range(3) != 0);
            cycle();
        end
    endtask

    initial begin
        Reset = 1'b1;
        iPixelEn = 1'b0;
        iMode = 2'b00;
        for (int i = 0; i < 2; i++) begin
            prev_hs[i] = 1'b0; prev_vs[i] = 1'b0;
            hs_pulses[i] = 0; vs_pulses[i] = 0;
            fs_tick[i] = 0; frame_len[i] = 0; fs_hit[i] = 1'b0;
        end
        tick_ctr = 0;
        test_reset();
        test_timing();
        test_bars(2'b01);
        test_bars(2'b10);
        test_mode_switch();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached in %s", scen);
        $fatal(1, "watchdog");
    end

endmodule
